two_to_four_decoder_seq: RTL and testbench
==========================================

TWO_TO_FOUR_DECODER_SEQ -- requirements
Module: two_to_four_decoder_seq

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 4, number of cycles a decoded one-hot word is driven; legal range 1..255.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; asynchronous and active-high.
REQ-004 SHALL have port A  input  2  binary code to decode.
REQ-005 SHALL have port valid_in  input  1  A is valid this cycle.
REQ-006 SHALL have port ready_out  output  1  block accepts a code this cycle.
REQ-007 SHALL have port F  output  4  registered one-hot decoded word.
REQ-008 SHALL have port busy  output  1  high while in HOLD or GAP.
REQ-009 SHALL have port done  output  1  one-cycle pulse at the end of each decode.

Function
REQ-010 SHALL decode A as 00->0001, 01->0010, 10->0100, 11->1000, the inverse of the team's 4-to-2 encoder mapping.
REQ-011 SHALL implement states IDLE, HOLD and GAP.
REQ-012 SHALL drive ready_out=1 only in IDLE, combinationally from state.
REQ-013 SHALL accept a code when valid_in && ready_out at a clock edge, capturing A into a register at that edge.
REQ-014 SHALL, on accept, enter HOLD with F = decode(captured A) from the next cycle, so latency is 1 cycle.
REQ-015 SHALL hold F constant for exactly HOLD_CYCLES cycles, counted by a down-counter loaded with HOLD_CYCLES-1, even if A or valid_in change.
REQ-016 SHALL move from HOLD to GAP when the counter is 0, driving F=0000 for exactly one cycle (break-before-make).
REQ-017 SHALL assert done during the GAP cycle only, then return to IDLE.
REQ-018 SHALL ignore valid_in in HOLD and GAP, with no queuing and no dropped-code flag.
REQ-019 SHALL allow back-to-back codes: valid_in held high gives a period of HOLD_CYCLES+2 cycles (HOLD, GAP, one IDLE accept cycle).
REQ-020 SHALL drive busy=1 in HOLD and GAP, and busy=0 in IDLE.
REQ-021 SHALL keep F=0000 at all times outside HOLD, so F is never multi-hot.
REQ-022 SHALL size the counter at 8 bits; HOLD_CYCLES=1 gives a single-cycle HOLD.

Reset
REQ-023 SHALL, on rst=1 at any time including mid-HOLD, immediately force state=IDLE, F=0000, done=0, busy=0 and counter=0.
REQ-024 SHALL have ready_out=1 in the first cycle after rst deasserts.

Configuration
REQ-025 SHALL, with DECODER_COUNT_EN defined, add output dec_count[7:0], the number of accepted codes, saturating at 255 and reset to 0.
REQ-026 SHALL, without DECODER_COUNT_EN, not declare port dec_count and add no counter logic; all other behaviour is identical.

Structure
REQ-027 SHALL place the state enum (IDLE, HOLD, GAP) and the function or constant table for the 2-to-4 mapping in a shared package, decoder_pkg.
REQ-028 SHALL place the combinational 2-to-4 mapping in sub-module two_to_four_decoder_comb, instantiated once on the captured code register.
REQ-029 SHALL keep the FSM, counter and optional dec_count in the top module.

Verification
REQ-030 SHALL verify, with HOLD_CYCLES=4: accept A=10 at cycle 0 -> F=0100 for cycles 1-4, F=0000 and done=1 at cycle 5, ready_out=1 at cycle 6.
REQ-031 SHALL verify all four codes 00,01,10,11 -> F=0001,0010,0100,1000 respectively, with F never multi-hot.
REQ-032 SHALL verify valid_in held high with A toggling during HOLD -> F unchanged, and the next accept occurs only in IDLE, giving a period of 6 cycles.
REQ-033 SHALL verify rst asserted in the 2nd HOLD cycle -> F=0000, busy=0, done=0 asynchronously, and ready_out=1 after release.
REQ-034 SHALL verify HOLD_CYCLES=1 with back-to-back codes 01,11 -> F=0010 for 1 cycle, GAP, IDLE, then F=1000 for 1 cycle.
REQ-035 SHALL verify, with DECODER_COUNT_EN, 260 accepted codes -> dec_count=255 held (saturated), and 0 after reset.

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared types and the 2-to-4 mapping for the sequenced decoder.
package decoder_pkg;

   localparam int unsigned CNT_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HOLD = 2'd1,
      GAP  = 2'd2
   } state_t;

   // Inverse of the 4-to-2 encoder: code n lights bit n.
   function automatic logic [3:0] decode_2to4(input logic [1:0] code);
      logic [3:0] word;
      word       = 4'b0000;
      word[code] = 1'b1;
      return word;
   endfunction

endpackage

// File: rtl/two_to_four_decoder_comb.sv
// Combinational 2-to-4 one-hot mapping.
import decoder_pkg::*;

module two_to_four_decoder_comb (
   input  logic [1:0] code,
   output logic [3:0] word
);

   assign word = decode_2to4(code);

endmodule

// File: rtl/two_to_four_decoder_seq.sv
// Sequenced 2-to-4 decoder: hold one-hot word, one-cycle gap, done pulse.
// Optional accepted-code counter enabled by DECODER_COUNT_EN.
import decoder_pkg::*;

module two_to_four_decoder_seq #(
   parameter int unsigned HOLD_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] A,
   input  logic       valid_in,
   output logic       ready_out,
   output logic [3:0] F,
   output logic       busy,
   output logic       done
`ifdef DECODER_COUNT_EN
   ,
   output logic [7:0] dec_count
`endif
);

   localparam logic [CNT_W-1:0] HOLD_LOAD =
      CNT_W'(HOLD_CYCLES - 1);

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic [1:0]       code_q;
   logic [3:0]       dec_word;
   logic             accept;

   two_to_four_decoder_comb u_comb (
      .code (code_q),
      .word (dec_word)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         code_q <= 2'b00;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (accept) begin
            code_q <= A;
         end
      end
   end

   // F is gated by state so it is zero outside HOLD.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      ready_out = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      accept    = 1'b0;
      F         = 4'b0000;
      unique case (state)
         IDLE: begin
            ready_out = 1'b1;
            if (valid_in) begin
               accept    = 1'b1;
               state_nxt = HOLD;
               cnt_nxt   = HOLD_LOAD;
            end
         end
         HOLD: begin
            busy = 1'b1;
            F    = dec_word;
            if (cnt == '0) begin
               state_nxt = GAP;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         GAP: begin
            busy      = 1'b1;
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

`ifdef DECODER_COUNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dec_count <= 8'd0;
      end else if (accept && dec_count != 8'hFF) begin
         dec_count <= dec_count + 8'd1;
      end
   end
`else
`endif

endmodule

// File: tb/tb_two_to_four_decoder_seq.sv
// Scoreboard bench: HOLD_CYCLES=4 and HOLD_CYCLES=1 instances.
module tb_two_to_four_decoder_seq;

   typedef struct {
      logic [3:0] f;
      int         hold;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] a4 = 2'b00;
   logic       v4 = 1'b0;
   logic [1:0] a1 = 2'b00;
   logic       v1 = 1'b0;
   logic       ready4, busy4, done4;
   logic       ready1, busy1, done1;
   logic [3:0] f4, f1;
`ifdef DECODER_COUNT_EN
   logic [7:0] cnt4, cnt1;
`endif

   exp_t q4[$];
   exp_t q1[$];
   int   total = 0;
   int   passed = 0;
   int   run4 = 0;
   int   run1 = 0;
   exp_t cur4, cur1;

   logic [3:0] dec_tab [4] =
      '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

   always #5 clk = ~clk;

   two_to_four_decoder_seq #(.HOLD_CYCLES(4)) dut4 (
      .clk       (clk),
      .rst       (rst),
      .A         (a4),
      .valid_in  (v4),
      .ready_out (ready4),
      .F         (f4),
      .busy      (busy4),
      .done      (done4)
`ifdef DECODER_COUNT_EN
      ,
      .dec_count (cnt4)
`endif
   );

   two_to_four_decoder_seq #(.HOLD_CYCLES(1)) dut1 (
      .clk       (clk),
      .rst       (rst),
      .A         (a1),
      .valid_in  (v1),
      .ready_out (ready1),
      .F         (f1),
      .busy      (busy1),
      .done      (done1)
`ifdef DECODER_COUNT_EN
      ,
      .dec_count (cnt1)
`endif
   );

   task automatic check(input string name,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h",
                    name, act, exp);
   endtask

   task automatic fail(input string name);
      total++;
      $display("FAIL %s: got event expected none", name);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle4();
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (ready4) return;
      end
      fail("idle4_timeout");
   endtask

   task automatic wait_idle1();
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (ready1) return;
      end
      fail("idle1_timeout");
   endtask

   task automatic send4(input logic [1:0] a,
                        input logic [3:0] f);
      exp_t e;
      e.f  = f;
      e.hold = 4;
      q4.push_back(e);
      a4 = a;
      v4 = 1'b1;
      tick();
      v4 = 1'b0;
   endtask

   // Monitor for the HOLD_CYCLES=4 instance
   always @(negedge clk) begin
      if (rst) begin
         run4 = 0;
      end else begin
         check("onehot4", 32'($onehot0(f4)), 32'd1);
         if (f4 != 4'b0000) begin
            if (run4 == 0) begin
               if (q4.size() == 0) fail("q4_underflow");
               else begin
                  cur4 = q4.pop_front();
                  check("f4_word", 32'(f4), 32'(cur4.f));
               end
            end else begin
               check("f4_stable", 32'(f4), 32'(cur4.f));
            end
            run4++;
         end
         if (done4) begin
            if (run4 == 0) fail("done4_no_hold");
            else check("hold4_len", run4, cur4.hold);
            check("f4_gap", 32'(f4), 32'd0);
            run4 = 0;
         end
      end
   end

   // Monitor for the HOLD_CYCLES=1 instance
   always @(negedge clk) begin
      if (rst) begin
         run1 = 0;
      end else begin
         check("onehot1", 32'($onehot0(f1)), 32'd1);
         if (f1 != 4'b0000) begin
            if (run1 == 0) begin
               if (q1.size() == 0) fail("q1_underflow");
               else begin
                  cur1 = q1.pop_front();
                  check("f1_word", 32'(f1), 32'(cur1.f));
               end
            end else begin
               check("f1_stable", 32'(f1), 32'(cur1.f));
            end
            run1++;
         end
         if (done1) begin
            if (run1 == 0) fail("done1_no_hold");
            else check("hold1_len", run1, cur1.hold);
            check("f1_gap", 32'(f1), 32'd0);
            run1 = 0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] ef4 [6];
      logic       ed4 [6];
      logic       er4 [6];
      logic [3:0] ef1 [5];
      logic       ed1 [5];
      logic       er1 [5];
      exp_t       e;
      ef4 = '{4'b0100, 4'b0100, 4'b0100, 4'b0100,
              4'b0000, 4'b0000};
      ed4 = '{0, 0, 0, 0, 1, 0};
      er4 = '{0, 0, 0, 0, 0, 1};
      ef1 = '{4'b0010, 4'b0000, 4'b0000, 4'b1000, 4'b0000};
      ed1 = '{0, 1, 0, 0, 1};
      er1 = '{0, 0, 1, 0, 0};

      // reset state
      #12;
      check("rst_f", 32'(f4), 32'd0);
      check("rst_busy", 32'(busy4), 32'd0);
      check("rst_done", 32'(done4), 32'd0);
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("rst_ready4", 32'(ready4), 32'd1);
      check("rst_ready1", 32'(ready1), 32'd1);

      // A=10 timeline: cycles 1..6 after accept
      tick();
      send4(2'b10, 4'b0100);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("t_f", 32'(f4), 32'(ef4[i]));
         check("t_done", 32'(done4), 32'(ed4[i]));
         check("t_ready", 32'(ready4), 32'(er4[i]));
      end

      // all four codes
      for (int c = 0; c < 4; c++) begin
         tick();
         send4(2'(c), dec_tab[c]);
         wait_idle4();
      end

      // valid held, A toggling: accepts at k=0,6,12
      tick();
      v4 = 1'b1;
      for (int k = 0; k < 18; k++) begin
         a4 = 2'(k % 4);
         check("period_ready", 32'(ready4),
               32'(k % 6 == 0));
         if (k % 6 == 0) begin
            e.f  = dec_tab[k % 4];
            e.hold = 4;
            q4.push_back(e);
         end
         tick();
      end
      v4 = 1'b0;
      wait_idle4();

      // reset in the 2nd HOLD cycle
      tick();
      send4(2'b11, 4'b1000);
      tick();
      #2;
      rst = 1'b1;
      #1;
      check("arst_f", 32'(f4), 32'd0);
      check("arst_busy", 32'(busy4), 32'd0);
      check("arst_done", 32'(done4), 32'd0);
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("arst_ready", 32'(ready4), 32'd1);

      // HOLD_CYCLES=1 back-to-back 01,11
      tick();
      e.hold = 1;
      e.f = 4'b0010;
      q1.push_back(e);
      e.f = 4'b1000;
      q1.push_back(e);
      a1 = 2'b01;
      v1 = 1'b1;
      tick();
      a1 = 2'b11;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("b2b_f", 32'(f1), 32'(ef1[i]));
         check("b2b_done", 32'(done1), 32'(ed1[i]));
         check("b2b_ready", 32'(ready1), 32'(er1[i]));
      end
      v1 = 1'b0;
      wait_idle1();

`ifdef DECODER_COUNT_EN
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("cnt_rst", 32'(cnt1), 32'd0);
      e.hold = 1;
      v1 = 1'b1;
      for (int k = 0; k < 780; k++) begin
         a1 = 2'((k / 3) % 4);
         if (k % 3 == 0) begin
            e.f = dec_tab[(k / 3) % 4];
            q1.push_back(e);
         end
         tick();
      end
      v1 = 1'b0;
      wait_idle1();
      check("cnt_sat", 32'(cnt1), 32'd255);
      tick();
      check("cnt_hold", 32'(cnt1), 32'd255);
      rst = 1'b1;
      #1;
      check("cnt_clr", 32'(cnt1), 32'd0);
      tick();
      rst = 1'b0;
`endif

      tick();
      tick();
      check("q4_drained", q4.size(), 32'd0);
      check("q1_drained", q1.size(), 32'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
